// File: rtl/seq_detector_pkg.sv
// Shared definitions for the 1101 serial pattern detector: state encoding and
// the reference pattern used by bench models.
package seq_detector_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        S11  = 3'd2,
        S110 = 3'd3,
        DET  = 3'd4
    } state_t;

    localparam logic [3:0] PATTERN = 4'b1101;

endpackage

// File: rtl/seq_detector.sv
// Moore detector for serial pattern 1101 (oldest first), overlapping hits allowed.
// Latency: z rises on the edge that samples the final '1', high for one cycle.
// Backpressure: none; w is sampled every cycle and z cannot be stalled.
module seq_detector
    import seq_detector_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic w,
    output logic z
);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // States track the longest received suffix that is a prefix of 1101.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = w ? S1  : IDLE;
            S1:      state_d = w ? S11 : IDLE;
            S11:     state_d = w ? S11 : S110;
            S110:    state_d = w ? DET : IDLE;
            DET:     state_d = w ? S11 : IDLE;
            // Unused codes fall back to IDLE so a corrupted register self-heals.
            default: state_d = IDLE;
        endcase
    end

    assign z = (state_q == DET);

endmodule

// File: tb/tb_seq_detector.sv
// Bench for seq_detector: history-based reference model feeds an expected-z queue.
module tb_seq_detector;
    import seq_detector_pkg::*;

    logic clk;
    logic rst_n;
    logic w;
    logic z;

    int checks = 0;
    int errors = 0;

    logic [3:0] hist;
    int         hist_cnt;
    logic       exp_q[$];

    seq_detector dut (
        .clk   (clk),
        .rst_n (rst_n),
        .w     (w),
        .z     (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        hist     = 4'b0000;
        hist_cnt = 0;
    endtask

    // Drive one bit, predict z from the raw sample history, compare after the edge.
    task automatic send_bit(input string tag, input logic b);
        logic e;
        @(negedge clk);
        w        = b;
        hist     = {hist[2:0], b};
        hist_cnt = hist_cnt + 1;
        exp_q.push_back((hist_cnt >= 4) && (hist == PATTERN));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got z=%0b", tag, z);
        end else begin
            e = exp_q.pop_front();
            check(tag, {31'd0, z}, {31'd0, e});
        end
    endtask

    task automatic send_seq(input string tag, input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit($sformatf("%s[%0d]", tag, n - 1 - i), bits[i]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        w     = 1'b0;
        model_clear();

        // Reset held with w toggling: z and state must stay idle.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            w = ~w;
            @(posedge clk);
            #1;
            check($sformatf("rst_z[%0d]", i), {31'd0, z}, 32'd0);
            check($sformatf("rst_state[%0d]", i), {29'd0, dut.state_q}, {29'd0, IDLE});
        end
        @(negedge clk);
        rst_n = 1'b1;

        send_seq("main", 16'b111_0110_1010, 11);

        model_clear();
        send_bit("sep", 1'b0);
        model_clear();
        send_seq("overlap", 16'b110_1101, 7);

        model_clear();
        send_bit("sep2", 1'b0);
        model_clear();
        send_seq("near", 16'b10_1110_0101, 10);

        // Async reset pulse between edges mid-pattern.
        send_seq("pre_rst", 16'b110, 3);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_z", {31'd0, z}, 32'd0);
        check("arst_state", {29'd0, dut.state_q}, {29'd0, IDLE});
        rst_n = 1'b1;
        model_clear();
        send_bit("lone1", 1'b1);
        send_seq("post_rst", 16'b1101, 4);
        check("post_rst_hit", {31'd0, z}, 32'd1);

        // Reset while in DET: z must drop before the next clock edge.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("det_rst_z", {31'd0, z}, 32'd0);
        check("det_rst_state", {29'd0, dut.state_q}, {29'd0, IDLE});
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        send_seq("after_det_rst", 16'b0110_1, 5);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
